// File: rtl/axil_ram_bridge_pkg.sv
// Shared types and helpers for the AXI4-Lite to simple-RAM bridge.
`timescale 1ns/1ps
package axil_pkg;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ISSUE,
    R_CAPT,
    R_RESP
  } rstate_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_COMMIT,
    W_RESP
  } wstate_e;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_DECERR = 2'b11;
  localparam logic [63:0] ALIGN_MASK  = ~64'h7;

  // 65-bit compare so a window that ends at the top of the address space cannot wrap.
  function automatic logic addr_in_range(input logic [63:0] addr,
                                         input logic [63:0] base,
                                         input logic [63:0] size);
    logic [64:0] a;
    logic [64:0] lo;
    logic [64:0] hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = lo + {1'b0, size} - 65'd1;
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/axil_ram_bridge_if.sv
// AXI4-Lite bus bundle (64-bit address and data) with master/slave views.
`timescale 1ns/1ps
interface axil_ram_bridge_if;
  logic        awvalid;
  logic        awready;
  logic [63:0] awaddr;
  logic        wvalid;
  logic        wready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        arvalid;
  logic        arready;
  logic [63:0] araddr;
  logic        rvalid;
  logic        rready;
  logic [63:0] rdata;
  logic [1:0]  rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axil_ram_bridge.sv
// AXI4-Lite slave driving the two-port simulation RAM; independent read and write
// FSMs, with a read stalled while a write commits so it observes the new data.
`timescale 1ns/1ps
module axil_ram_bridge
  import axil_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter logic [63:0] MEM_SIZE  = 64'h0800_0000
) (
  input  logic               clock,
  input  logic               reset,
  axil_ram_bridge_if.slave   bus,
  output logic [63:0]        ram_raddr,
  input  logic [63:0]        ram_rdata,
  output logic [63:0]        ram_waddr,
  output logic [63:0]        ram_wdata,
  output logic [7:0]         ram_wstrb,
  output logic               ram_wen
);

  rstate_e     rstate;
  logic        ar_oor;
  logic [63:0] rdata_q;

  wstate_e     wstate;
  logic        aw_held;
  logic        w_held;
  logic        w_oor;
  logic [63:0] awaddr_q;
  logic [63:0] wdata_q;
  logic [7:0]  wstrb_q;

  logic        aw_take;
  logic        w_take;
  logic        aw_have;
  logic        w_have;
  logic [63:0] waddr_sel;
  logic [63:0] wdata_sel;
  logic [7:0]  wstrb_sel;
  logic        wr_ok;

  // ---- read path: IDLE -> ISSUE -> CAPT -> RESP ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rstate      <= R_IDLE;
      bus.arready <= 1'b0;
      bus.rvalid  <= 1'b0;
      bus.rdata   <= '0;
      bus.rresp   <= RESP_OKAY;
      ram_raddr   <= '0;
      ar_oor      <= 1'b0;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (bus.arready && bus.arvalid) begin
            bus.arready <= 1'b0;
            ram_raddr   <= bus.araddr & ALIGN_MASK;
            ar_oor      <= !addr_in_range(bus.araddr, BASE_ADDR, MEM_SIZE);
            rstate      <= R_ISSUE;
          end else begin
            bus.arready <= 1'b1;
          end
        end
        // A commit in flight this cycle would race the RAM read; wait it out.
        R_ISSUE: begin
          if (!ram_wen) rstate <= R_CAPT;
        end
        R_CAPT: begin
          rstate <= R_RESP;
        end
        R_RESP: begin
          if (!bus.rvalid) begin
            bus.rvalid <= 1'b1;
            bus.rdata  <= rdata_q;
            bus.rresp  <= ar_oor ? RESP_DECERR : RESP_OKAY;
          end else if (bus.rready) begin
            bus.rvalid  <= 1'b0;
            bus.arready <= 1'b1;
            rstate      <= R_IDLE;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  // RAM data is discarded for out-of-range reads so nothing leaks onto the bus.
  always_ff @(posedge clock) begin
    if (rstate == R_CAPT) rdata_q <= ar_oor ? 64'd0 : ram_rdata;
  end

  // ---- write path: IDLE (collect AW and W) -> COMMIT -> RESP ----
  assign aw_take   = bus.awready && bus.awvalid;
  assign w_take    = bus.wready && bus.wvalid;
  assign aw_have   = aw_held || aw_take;
  assign w_have    = w_held || w_take;
  assign waddr_sel = aw_held ? awaddr_q : bus.awaddr;
  assign wdata_sel = w_held ? wdata_q : bus.wdata;
  assign wstrb_sel = w_held ? wstrb_q : bus.wstrb;
  assign wr_ok     = addr_in_range(waddr_sel, BASE_ADDR, MEM_SIZE);

  always_ff @(posedge clock) begin
    if (aw_take) awaddr_q <= bus.awaddr;
    if (w_take) begin
      wdata_q <= bus.wdata;
      wstrb_q <= bus.wstrb;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wstate      <= W_IDLE;
      bus.awready <= 1'b0;
      bus.wready  <= 1'b0;
      bus.bvalid  <= 1'b0;
      bus.bresp   <= RESP_OKAY;
      aw_held     <= 1'b0;
      w_held      <= 1'b0;
      w_oor       <= 1'b0;
      ram_waddr   <= '0;
      ram_wdata   <= '0;
      ram_wstrb   <= '0;
      ram_wen     <= 1'b0;
    end else begin
      case (wstate)
        W_IDLE: begin
          aw_held     <= aw_have;
          w_held      <= w_have;
          bus.awready <= !aw_have;
          bus.wready  <= !w_have;
          if (aw_have && w_have) begin
            ram_waddr <= waddr_sel & ALIGN_MASK;
            ram_wdata <= wdata_sel;
            ram_wstrb <= wr_ok ? wstrb_sel : 8'h00;
            ram_wen   <= wr_ok;
            w_oor     <= !wr_ok;
            wstate    <= W_COMMIT;
          end
        end
        W_COMMIT: begin
          ram_wen   <= 1'b0;
          ram_wstrb <= 8'h00;
          wstate    <= W_RESP;
        end
        W_RESP: begin
          if (!bus.bvalid) begin
            bus.bvalid <= 1'b1;
            bus.bresp  <= w_oor ? RESP_DECERR : RESP_OKAY;
          end else if (bus.bready) begin
            bus.bvalid  <= 1'b0;
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            bus.awready <= 1'b1;
            bus.wready  <= 1'b1;
            wstate      <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_ram_bridge.sv
// Scoreboard bench for axil_ram_bridge with a behavioural RAMCtrl model.
`timescale 1ns/1ps
module tb_axil_ram_bridge;
  import axil_pkg::*;

  localparam logic [63:0] BASE    = 64'h8000_0000;
  localparam logic [63:0] SIZE    = 64'h0800_0000;
  localparam logic [63:0] GARBAGE = 64'hDEAD_BEEF_0BAD_F00D;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] ram_raddr, ram_rdata, ram_waddr, ram_wdata;
  logic [7:0]  ram_wstrb;
  logic        ram_wen;

  axil_ram_bridge_if bus ();

  axil_ram_bridge #(.BASE_ADDR(BASE), .MEM_SIZE(SIZE)) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata), .ram_waddr(ram_waddr),
    .ram_wdata(ram_wdata), .ram_wstrb(ram_wstrb), .ram_wen(ram_wen)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
    int          lat;
  } rexp_t;

  rexp_t      rq[$];
  logic [1:0] wq[$];
  rexp_t      rcur;
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n,
                                        input logic [7:0] s);
    logic [63:0] r;
    r = o;
    for (int i = 0; i < 8; i++) if (s[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  function automatic logic tb_in_range(input logic [63:0] a);
    return (a >= BASE) && ((a - BASE) < SIZE);
  endfunction

  // RAMCtrl model: read data one edge after raddr; a same-edge write is not yet visible.
  logic [63:0] mem   [0:63] = '{default: GARBAGE};
  logic [63:0] model [0:63] = '{default: GARBAGE};

  always @(posedge clock) begin
    ram_rdata <= mem[ram_raddr[8:3]];
    if (ram_wen) mem[ram_waddr[8:3]] <= merge(mem[ram_waddr[8:3]], ram_wdata, ram_wstrb);
  end

  int          cyc = 0;
  int          ar_edge = 0;
  int          rv_lat = 0;
  logic        rv_prev = 1'b0;
  int          wen_cnt = 0;
  logic [63:0] last_waddr = '0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (bus.arvalid && bus.arready) ar_edge = cyc + 1;
    if (bus.rvalid && !rv_prev) rv_lat = cyc - ar_edge;
    rv_prev = bus.rvalid;
    if (ram_wen) begin
      wen_cnt++;
      last_waddr = ram_waddr;
    end
    if (bus.rvalid && bus.rready) begin
      if (rq.size() == 0) chk("r_unexpected", rq.size(), 1);
      else begin
        rcur = rq.pop_front();
        chk("rdata", bus.rdata, rcur.data);
        chk("rresp", bus.rresp, rcur.resp);
        chk("rlat", rv_lat, rcur.lat);
      end
    end
    if (bus.bvalid && bus.bready) begin
      if (wq.size() == 0) chk("b_unexpected", wq.size(), 1);
      else chk("bresp", bus.bresp, wq.pop_front());
    end
  end

  task automatic send_aw(input logic [63:0] a);
    bit ok = 1'b0;
    bus.awvalid = 1'b1;
    bus.awaddr  = a;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (bus.awready) begin ok = 1'b1; break; end
    end
    @(posedge clock); #1;
    bus.awvalid = 1'b0;
    chk("aw_hs", ok, 1);
  endtask

  task automatic send_w(input logic [63:0] d, input logic [7:0] s);
    bit ok = 1'b0;
    bus.wvalid = 1'b1;
    bus.wdata  = d;
    bus.wstrb  = s;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (bus.wready) begin ok = 1'b1; break; end
    end
    @(posedge clock); #1;
    bus.wvalid = 1'b0;
    chk("w_hs", ok, 1);
  endtask

  task automatic send_ar(input logic [63:0] a);
    bit ok = 1'b0;
    bus.arvalid = 1'b1;
    bus.araddr  = a;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (bus.arready) begin ok = 1'b1; break; end
    end
    @(posedge clock); #1;
    bus.arvalid = 1'b0;
    chk("ar_hs", ok, 1);
  endtask

  task automatic axi_write(input logic [63:0] a, input logic [63:0] d,
                           input logic [7:0] s, input int w_lead);
    int n0;
    if (tb_in_range(a)) begin
      wq.push_back(2'b00);
      model[a[8:3]] = merge(model[a[8:3]], d, s);
    end else begin
      wq.push_back(2'b11);
    end
    if (w_lead == 0) begin
      fork
        send_aw(a);
        send_w(d, s);
      join
    end else begin
      send_w(d, s);
      n0 = wen_cnt;
      repeat (w_lead) begin
        @(negedge clock);
        chk("wlead_bvalid", bus.bvalid, 0);
        chk("wlead_wen", wen_cnt, n0);
      end
      @(posedge clock); #1;
      send_aw(a);
    end
  endtask

  task automatic axi_read(input logic [63:0] a, input logic [63:0] d,
                          input logic [1:0] r, input int lat);
    rq.push_back('{data: d, resp: r, lat: lat});
    send_ar(a);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (rq.size() + wq.size()) != 0; i++) @(posedge clock);
    chk("drain", rq.size() + wq.size(), 0);
    @(posedge clock); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    bus.awvalid = 0; bus.awaddr = 0; bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0;
    bus.arvalid = 0; bus.araddr = 0; bus.bready = 1; bus.rready = 1;

    // reset values
    repeat (3) @(posedge clock);
    #1;
    chk("rst_arready", bus.arready, 0);
    chk("rst_awready", bus.awready, 0);
    chk("rst_wready", bus.wready, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_bvalid", bus.bvalid, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_ram_wen", ram_wen, 0);
    chk("rst_ram_raddr", ram_raddr, 0);
    reset = 1'b0;
    #1;
    chk("ready_before_edge", bus.arready, 0);
    @(posedge clock); #1;
    chk("arready_up", bus.arready, 1);
    chk("awready_up", bus.awready, 1);
    chk("wready_up", bus.wready, 1);

    // single write then read
    axi_write(64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 0);
    drain();
    axi_read(64'h8000_0010, 64'h1122_3344_5566_7788, 2'b00, 3);
    drain();

    // partial strobe with unaligned address
    axi_write(64'h8000_0020, 64'h0, 8'hFF, 0);
    drain();
    axi_write(64'h8000_0023, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 0);
    drain();
    chk("waddr_align", last_waddr, 64'h8000_0020);
    axi_read(64'h8000_0020, 64'h0000_0000_AAAA_AAAA, 2'b00, 3);
    drain();

    // W two cycles ahead of AW
    n0 = wen_cnt;
    axi_write(64'h8000_0030, 64'hCAFE_F00D_1234_5678, 8'hFF, 2);
    drain();
    chk("wlead_pulses", wen_cnt - n0, 1);
    axi_read(64'h8000_0030, 64'hCAFE_F00D_1234_5678, 2'b00, 3);
    drain();

    // same-cycle write and read of one address
    axi_write(64'h8000_0040, 64'h1234, 8'hFF, 0);
    drain();
    fork
      axi_write(64'h8000_0040, 64'h5, 8'hFF, 0);
      axi_read(64'h8000_0040, 64'h5, 2'b00, 4);
    join
    drain();

    // range boundaries
    axi_read(64'h7FFF_FFF8, 64'h0, 2'b11, 3);
    drain();
    axi_read(64'h87FF_FFF8, model[63], 2'b00, 3);
    drain();
    n0 = wen_cnt;
    axi_write(BASE + SIZE, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0);
    drain();
    chk("oor_wen", wen_cnt, n0);

    // read response backpressure
    bus.rready = 1'b0;
    axi_read(64'h8000_0010, 64'h1122_3344_5566_7788, 2'b00, 3);
    for (int i = 0; i < 20 && !bus.rvalid; i++) @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      chk("bp_rvalid", bus.rvalid, 1);
      chk("bp_rdata", bus.rdata, 64'h1122_3344_5566_7788);
      @(negedge clock);
    end
    @(posedge clock); #1;
    bus.rready = 1'b1;
    drain();

    // reset during the commit cycle drops the write
    bus.awvalid = 1'b1; bus.awaddr = 64'h8000_0010;
    bus.wvalid  = 1'b1; bus.wdata  = 64'hBADB_ADBA_DBAD_BADB; bus.wstrb = 8'hFF;
    @(negedge clock);
    chk("rst_hs", bus.awready && bus.wready, 1);
    @(posedge clock); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    chk("commit_wen", ram_wen, 1);
    reset = 1'b1;
    #1;
    chk("async_wen", ram_wen, 0);
    chk("async_wstrb", ram_wstrb, 0);
    chk("async_waddr", ram_waddr, 0);
    chk("async_awready", bus.awready, 0);
    chk("async_arready", bus.arready, 0);
    chk("async_bvalid", bus.bvalid, 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock); #1;
    axi_read(64'h8000_0010, 64'h1122_3344_5566_7788, 2'b00, 3);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
